rv_mem_responder: RTL
=====================

# rv_mem_responder

Memory-side responder for the core's instruction/data bus: serves combinational instruction fetches and data reads, commits data writes on the clock edge, and owns the program image. After reset, a loader FSM accepts a word stream into memory from address 0 while holding the core. It then releases the core and behaves as plain dual-port RAM. It sits between the testbench/boot source and the single-cycle core, driving `idata`/`ddata_r` against the core's `iaddr`/`daddr`/`ddata_w`/`d_rw`.

## Interface
- `DATA_WIDTH`, 32 — word width; only 32 is supported.
- `MEM_DEPTH`, 1024 — number of words; must be a power of two, ≥ 4.
- `CLK`  in  1 — single clock, rising edge.
- `RESET`  in  1 — asynchronous, active-high reset.
- `iaddr`  in  32 — instruction byte address from core.
- `idata`  out  32 — instruction word.
- `daddr`  in  32 — data byte address from core.
- `ddata_w`  in  32 — data write word.
- `d_rw`  in  1 — 1 = write, 0 = read.
- `ddata_r`  out  32 — data read word.
- `ld_valid`  in  1 — load word valid.
- `ld_data`  in  32 — load word.
- `ld_last`  in  1 — marks final load word.
- `ld_ready`  out  1 — loader accepts a word this cycle.
- `core_hold`  out  1 — core must stay in reset while 1.
- `ld_count`  out  $clog2(MEM_DEPTH)+1 — words loaded so far.
- `err`  out  1 — sticky fault flag.

## Operation
- FSM states: LOAD, RUN, ERR. `RESET` forces LOAD asynchronously.
- Reset values: `core_hold`=1, `ld_ready`=1, `ld_count`=0, `err`=0. RAM contents are not cleared; unloaded words keep their previous value.
- Address decode: word index is `addr[$clog2(MEM_DEPTH)+1:2]`.
  - An access is invalid if `addr[1:0]`≠0 or `addr` ≥ 4·MEM_DEPTH.
  - Invalid read returns 0. Invalid write is dropped. Either sets `err` in RUN.
- LOAD:
  - `ld_ready`=1. Transfer occurs on `ld_valid && ld_ready` at the edge.
  - Each transfer writes `ld_data` to index `ld_count`, then increments `ld_count`.
  - `idata` = 0x00000013 (NOP) and `ddata_r` = 0. Core `d_rw` writes are ignored.
- LOAD exits:
  - Transfer with `ld_last`=1 → RUN.
  - Transfer that fills index MEM_DEPTH-1 with `ld_last`=0 → ERR.
- RUN:
  - `ld_ready`=0, `core_hold`=0.
  - `idata` = RAM[iaddr index] and `ddata_r` = RAM[daddr index]. Both are combinational.
  - `d_rw`=1 writes `ddata_w` at the edge.
  - Load-port inputs are ignored.
- ERR: `ld_ready`=0, `core_hold`=1, `err`=1. Outputs behave as in LOAD. The only exit is reset.
- `err` is sticky until `RESET`.

## Timing
- Read latency: 0 cycles (combinational from address).
- Write: visible to both read ports from the cycle after the edge.
- Same-cycle write and read to one index: both ports return old data; new data appears after the edge.
- `core_hold` falls at the same edge that accepts the `ld_last` transfer. The core's first fetch is the following cycle.
- `ld_count` updates at the transfer edge and holds in RUN/ERR.
- Reset mid-load: immediate return to LOAD with `ld_count`=0. Already-written words persist.
- `ld_valid` without `ld_ready`: no effect, no error.

## Structure
- Package `rv_mem_pkg`:
  - state enum `ld_state_t` (LOAD, RUN, ERR)
  - `NOP_INSTR` = 32'h00000013
  - address-valid function
- Sub-module `rv_mem_array`: MEM_DEPTH×32 storage with two asynchronous read ports and one synchronous write port.
- The top level holds the FSM, counter, write-port mux (loader vs core), and output gating.

## Test plan
- Reset, then load 0xA, 0xB, 0xC with `ld_last` on the third → `core_hold` falls at the third edge, `ld_count`=3; RUN reads at iaddr 0/4/8 return 0xA/0xB/0xC.
- RUN, write 0xDEADBEEF at daddr 0x10 while reading 0x10 → `ddata_r` shows old value that cycle and 0xDEADBEEF the next; `idata` at iaddr 0x10 also shows it.
- RUN, read daddr 0x6 (misaligned) and write daddr 4·MEM_DEPTH → `ddata_r`=0, no RAM change, `err`=1 and stays 1.
- Load MEM_DEPTH words with `ld_last` never set → ERR, `ld_ready`=0, `core_hold`=1, `err`=1, `idata`=0x00000013.
- Assert `RESET` after 2 of 4 load words → `ld_count`=0 immediately; reload of 4 words then reaches RUN with correct contents.
- In LOAD, drive `d_rw`=1 to daddr 0 with 0x55 → RAM[0] unchanged; `ddata_r`=0 throughout.

Source files
------------

// File: rtl/rv_mem_responder_pkg.sv
// Shared types and helpers for the boot-loading memory responder.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } ld_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Word-aligned and inside the array; anything else is a faulting access.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
  endfunction

endpackage

// File: rtl/rv_mem_responder_if.sv
// Core bus plus loader stream seen by the memory responder.
interface rv_mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
);
  logic [31:0]                 iaddr;
  logic [DATA_WIDTH-1:0]       idata;
  logic [31:0]                 daddr;
  logic [DATA_WIDTH-1:0]       ddata_w;
  logic                        d_rw;
  logic [DATA_WIDTH-1:0]       ddata_r;
  logic                        ld_valid;
  logic [DATA_WIDTH-1:0]       ld_data;
  logic                        ld_last;
  logic                        ld_ready;
  logic                        core_hold;
  logic [$clog2(MEM_DEPTH):0]  ld_count;
  logic                        err;

  modport master (
    output iaddr, daddr, ddata_w, d_rw, ld_valid, ld_data, ld_last,
    input  idata, ddata_r, ld_ready, core_hold, ld_count, err
  );

  modport slave (
    input  iaddr, daddr, ddata_w, d_rw, ld_valid, ld_data, ld_last,
    output idata, ddata_r, ld_ready, core_hold, ld_count, err
  );
endinterface

// File: rtl/rv_mem_responder_array.sv
// Word storage: two combinational read ports, one write port committed on the rising edge.
module rv_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]         raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // No reset: program image must survive a reset pulse.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/rv_mem_responder.sv
// Boot loader + dual-port RAM for a single-cycle core; reads are combinational, writes land on the edge.
// Loader is ready every LOAD cycle; the core is held until the last word is accepted.
module rv_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  rv_mem_responder_if.slave   bus
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = AW + 1;

  ld_state_t         state_q, state_d;
  logic [CW-1:0]     ld_count_q, ld_count_d;
  logic              err_q, err_d;

  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rd_i, rd_d;
  logic                  i_ok, d_ok;

  assign i_ok = addr_ok(bus.iaddr, MEM_DEPTH);
  assign d_ok = addr_ok(bus.daddr, MEM_DEPTH);

  rv_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk     (CLK),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (bus.iaddr[AW+1:2]),
    .rdata_a (rd_i),
    .raddr_b (bus.daddr[AW+1:2]),
    .rdata_b (rd_d)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= LOAD;
      ld_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_count_q <= ld_count_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    err_d      = err_q;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    case (state_q)
      LOAD: begin
        if (bus.ld_valid) begin
          we         = 1'b1;
          waddr      = ld_count_q[AW-1:0];
          wdata      = bus.ld_data;
          ld_count_d = ld_count_q + CW'(1);
          if (bus.ld_last) begin
            state_d = RUN;
          end else if (ld_count_q == CW'(MEM_DEPTH - 1)) begin
            // Image overflowed the array without a terminator.
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (!i_ok || !d_ok) begin
          err_d = 1'b1;
        end
        if (bus.d_rw && d_ok) begin
          we    = 1'b1;
          waddr = bus.daddr[AW+1:2];
          wdata = bus.ddata_w;
        end
      end
      default: begin
        err_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    bus.ld_ready  = (state_q == LOAD);
    bus.core_hold = (state_q != RUN);
    bus.ld_count  = ld_count_q;
    bus.err       = err_q;
    bus.idata     = NOP_INSTR;
    bus.ddata_r   = '0;
    if (state_q == RUN) begin
      bus.idata   = i_ok ? rd_i : '0;
      bus.ddata_r = d_ok ? rd_d : '0;
    end
  end

endmodule
